cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead add/subtract unit. Successor to the 4-bit CLA.
//  Splits a WIDTH-bit operation into GROUP-bit CLA slices, one slice per pipeline stage.
//  The carry passes between stages through registers. Throughput is one op/cycle.
//  Sits between operand-select logic and the result bus, with valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of GROUP
//  GROUP   8  bits per CLA slice; NSTG = WIDTH/GROUP pipeline stages (NSTG>=1)
//  (elaboration error if WIDTH % GROUP != 0 or GROUP < 1)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry in (ignored when in_sub=1)
//  in_sub     in   1      0: A+B+cin   1: A-B (computed as A+~B+1)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow = carry into MSB ^ carry out of MSB
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits = 0; out_valid, out_sum, out_cout,
//    out_ovf = 0; out_zero = 0. Data in flight is discarded. The first beat after reset
//    release is accepted normally.
//  - Slice k (0..NSTG-1): G=A&B', P=A^B' with B'=sub?~B:B. Carries are lookahead
//    within the slice: c[i+1]=G[i]|P[i]&c[i], sum=P^c. Slice-0 carry in = sub?1:cin;
//    slice k>0 takes the registered carry out of slice k-1.
//  - Pipeline: slice k is evaluated from stage register k (stage 0 = the input port) and
//    written to stage k+1. Each stage register holds valid, remaining A/B' slices,
//    completed sum slices, and the carry. The final stage also holds the MSB carry-in for ovf.
//  - Latency: a beat accepted at clock edge E appears (out_valid=1) after edge E+NSTG-1,
//    i.e. NSTG cycles. NSTG=1 is a single registered CLA.
//  - Handshake: advance = !out_valid | out_ready. All stages shift together when
//    advance=1 and hold when advance=0. in_ready = advance (combinational).
//    A beat transfers when in_valid&in_ready; when in_valid=0 during advance, a bubble
//    (valid=0) enters.
//  - Stall: while out_valid&!out_ready, out_* hold stable and in_ready=0. No beat is lost,
//    duplicated or reordered. Bubbles are not collapsed during a stall.
//  - out_valid may assert with in_valid low (drain). in_* are sampled only on a transfer.
//  - Width rules: all arithmetic is modulo 2^WIDTH. cout/ovf are derived as above.
//    out_zero is computed on the registered final sum.
//  - Simultaneous output pop and input push in one cycle are legal and preserve full
//    throughput.
// TESTING  (WIDTH=32, GROUP=8, NSTG=4, out_ready=1 unless stated)
//  1. add 0xFFFFFFFF+0x00000001 cin=0 -> 4 cycles later sum=0, cout=1, zero=1, ovf=0.
//  2. add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, ovf=1, cout=0.
//     sub 0x80000000-1 -> 0x7FFFFFFF, ovf=1, cout=1.
//  3. sub 5-7 (cin=1 ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0.
//     sub 9-9 -> sum=0, cout=1, zero=1.
//  4. Stream 200 random back-to-back beats (mixed add/sub, random cin) -> exactly one
//     result per cycle, in order, matching the reference model after 4-cycle latency.
//  5. Fill 4 beats, then hold out_ready=0 for 3 cycles -> in_ready=0 and out_* stable.
//     Release -> 4 results in order with no gaps or duplicates.
//  6. Pulse rst_n low with 3 beats in flight -> outputs 0 immediately and none of those
//     beats ever appear. A new beat after release emerges 4 cycles later.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/subtract unit: one GROUP-bit slice per stage,
// carries handed between stages through registers, valid/ready on both ends.
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NSTG = (GROUP < 1) ? 1 : WIDTH / GROUP;

   if (GROUP < 1 || (WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad
      $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
   end

   logic             adv;

   logic             rv [1:NSTG];
   logic [WIDTH-1:0] ra [1:NSTG];
   logic [WIDTH-1:0] rb [1:NSTG];
   logic [WIDTH-1:0] rs [1:NSTG];
   logic             rc [1:NSTG];
   logic             rm;

   logic             sv [0:NSTG-1];
   logic [WIDTH-1:0] sa [0:NSTG-1];
   logic [WIDTH-1:0] sb [0:NSTG-1];
   logic [WIDTH-1:0] ss [0:NSTG-1];
   logic             sc [0:NSTG-1];

   logic [WIDTH-1:0] ns [0:NSTG-1];
   logic             nc [0:NSTG-1];
   logic             nm;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Source of slice k: the input port for k=0, stage register k otherwise.
   always_comb begin
      sv[0] = in_valid;
      sa[0] = in_a;
      sb[0] = in_sub ? ~in_b : in_b;
      ss[0] = '0;
      sc[0] = in_sub | in_cin;
      for (int k = 1; k < NSTG; k++) begin
         sv[k] = rv[k];
         sa[k] = ra[k];
         sb[k] = rb[k];
         ss[k] = rs[k];
         sc[k] = rc[k];
      end
   end

   always_comb begin
      logic cy;
      cy = 1'b0;
      nm = 1'b0;
      for (int k = 0; k < NSTG; k++) begin
         ns[k] = ss[k];
         cy    = sc[k];
         for (int i = 0; i < GROUP; i++) begin
            if (k == NSTG - 1 && i == GROUP - 1)
               nm = cy;
            ns[k][k*GROUP+i] = sa[k][k*GROUP+i] ^ sb[k][k*GROUP+i] ^ cy;
            cy = (sa[k][k*GROUP+i] & sb[k][k*GROUP+i]) |
                 ((sa[k][k*GROUP+i] ^ sb[k][k*GROUP+i]) & cy);
         end
         nc[k] = cy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= NSTG; k++) begin
            rv[k] <= 1'b0;
            ra[k] <= '0;
            rb[k] <= '0;
            rs[k] <= '0;
            rc[k] <= 1'b0;
         end
         rm <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < NSTG; k++) begin
            rv[k+1] <= sv[k];
            ra[k+1] <= sa[k];
            rb[k+1] <= sb[k];
            rs[k+1] <= ns[k];
            rc[k+1] <= nc[k];
         end
         rm <= nm;
      end
   end

   assign out_valid = rv[NSTG];
   assign out_sum   = rs[NSTG];
   assign out_cout  = rc[NSTG];
   assign out_ovf   = rc[NSTG] ^ rm;
   assign out_zero  = rv[NSTG] & ~|rs[NSTG];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, random stream against an
// arithmetic reference, stall and mid-flight reset sequences.
module tb_cla_pipe_adder;

   localparam int W    = 32;
   localparam int G    = 8;
   localparam int NSTG = W / G;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;

   cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout),
      .out_ovf(out_ovf), .out_zero(out_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   vec_t tbl [8];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   bit sb_on  = 0;
   logic [W+2:0] q [$];
   int ph_pops, ph_first, ph_last;

   // {zero, ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [W+2:0] model(logic [W-1:0] a, logic [W-1:0] b,
                                          logic cin, logic sub);
      logic [W-1:0] bb;
      logic [W:0]   f;
      logic         ovf;
      bb  = sub ? ~b : b;
      f   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
      ovf = (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]);
      return {(f[W-1:0] == '0), ovf, f[W], f[W-1:0]};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; at the falling edge the scoreboard sees both handshakes.
   task automatic tick();
      logic [W+2:0] e;
      @(negedge clk);
      if (sb_on) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("sb_extra_beat", 64'(out_sum), 64'hdead);
            end else begin
               e = q.pop_front();
               chk("sb_result", 64'({out_zero, out_ovf, out_cout, out_sum}), 64'(e));
               if (ph_pops == 0) ph_first = cyc;
               ph_last = cyc;
               ph_pops++;
            end
         end
         if (in_valid && in_ready)
            q.push_back(model(in_a, in_b, in_cin, in_sub));
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive_rand();
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
      in_cin   = 1'($urandom_range(0, 1));
      in_sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic run_vec(vec_t v, string name);
      int lat;
      in_valid = 1'b1;
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (out_valid || lat > 20) break;
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'(NSTG - 1));
      chk({name, "_sum"}, 64'(out_sum), 64'(v.sum));
      chk({name, "_cout"}, 64'(out_cout), 64'(v.cout));
      chk({name, "_ovf"}, 64'(out_ovf), 64'(v.ovf));
      chk({name, "_zero"}, 64'(out_zero), 64'(v.zero));
      @(posedge clk); #1;
   endtask

   task automatic phase_reset();
      ph_pops = 0; ph_first = 0; ph_last = 0;
   endtask

   initial begin
      logic [W-1:0] snap_sum;
      logic [2:0]   snap_flags;
      int           bound;

      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1};
      tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0};
      tbl[2] = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0};
      tbl[3] = '{32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 0};
      tbl[4] = '{32'h00000009, 32'h00000009, 0, 1, 32'h00000000, 1, 0, 1};
      tbl[5] = '{32'h00000001, 32'h00000002, 1, 0, 32'h00000004, 0, 0, 0};
      tbl[6] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1};
      tbl[7] = '{32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0};

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_sum", 64'(out_sum), 0);
      chk("rst_out_flags", 64'({out_cout, out_ovf, out_zero}), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_vec(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back random stream, one result per cycle expected.
      sb_on = 1'b1;
      phase_reset();
      for (int i = 0; i < 200; i++) begin
         drive_rand();
         tick();
      end
      in_valid = 1'b0;
      bound = 0;
      while (q.size() > 0 && bound < 20) begin
         tick();
         bound++;
      end
      chk("stream_pops", 64'(ph_pops), 200);
      chk("stream_no_gaps", 64'(ph_last - ph_first + 1), 64'(ph_pops));
      chk("stream_drained", 64'(q.size()), 0);

      // Fill with out_ready low, stall, then release with a push on the same cycle.
      phase_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_rand();
         tick();
      end
      snap_sum   = out_sum;
      snap_flags = {out_cout, out_ovf, out_zero};
      drive_rand();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 0);
         chk("stall_out_valid", 64'(out_valid), 1);
         chk("stall_sum", 64'(out_sum), 64'(snap_sum));
         chk("stall_flags", 64'({out_cout, out_ovf, out_zero}), 64'(snap_flags));
         @(posedge clk); #1;
         in_a = $urandom;
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      bound = 0;
      while (q.size() > 0 && bound < 20) begin
         tick();
         bound++;
      end
      chk("stall_pops", 64'(ph_pops), 5);
      chk("stall_no_gaps", 64'(ph_last - ph_first + 1), 64'(ph_pops));
      chk("stall_drained", 64'(q.size()), 0);

      // Asynchronous reset with one result showing and three beats behind it.
      sb_on = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_dummy: begin
            in_valid = 1'b1;
            in_a = tbl[i].a; in_b = tbl[i].b;
            in_cin = tbl[i].cin; in_sub = tbl[i].sub;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("prerst_out_valid", 64'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 0);
      chk("async_rst_sum", 64'(out_sum), 0);
      chk("async_rst_flags", 64'({out_cout, out_ovf, out_zero}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_ghost", 64'(out_valid), 0);
      end
      @(posedge clk); #1;
      run_vec(tbl[7], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
